// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
package tour_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StVert,
        StVwait,
        StHorz,
        StHwait,
        StDrain
    } tour_state_t;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [3:0] OPC_MOVE    = 4'h4;
    localparam logic [3:0] OPC_FANFARE = 4'h5;

    typedef struct packed {
        logic [15:0] vert;
        logic [15:0] horz;
    } leg_cmds_t;

    // Split a one-hot knight move into its vertical and horizontal leg commands.
    // Anything that is not one-hot yields all-zero commands.
    function automatic leg_cmds_t move_legs(input logic [7:0] move);
        leg_cmds_t legs;
        legs = '0;
        case (move)
            8'h01: begin legs.vert = {OPC_MOVE, HDG_N, 4'd2}; legs.horz = {OPC_FANFARE, HDG_E, 4'd1}; end
            8'h02: begin legs.vert = {OPC_MOVE, HDG_N, 4'd2}; legs.horz = {OPC_FANFARE, HDG_W, 4'd1}; end
            8'h04: begin legs.vert = {OPC_MOVE, HDG_N, 4'd1}; legs.horz = {OPC_FANFARE, HDG_W, 4'd2}; end
            8'h08: begin legs.vert = {OPC_MOVE, HDG_S, 4'd1}; legs.horz = {OPC_FANFARE, HDG_W, 4'd2}; end
            8'h10: begin legs.vert = {OPC_MOVE, HDG_S, 4'd2}; legs.horz = {OPC_FANFARE, HDG_W, 4'd1}; end
            8'h20: begin legs.vert = {OPC_MOVE, HDG_S, 4'd2}; legs.horz = {OPC_FANFARE, HDG_E, 4'd1}; end
            8'h40: begin legs.vert = {OPC_MOVE, HDG_S, 4'd1}; legs.horz = {OPC_FANFARE, HDG_E, 4'd2}; end
            8'h80: begin legs.vert = {OPC_MOVE, HDG_N, 4'd1}; legs.horz = {OPC_FANFARE, HDG_E, 4'd2}; end
            default: legs = '0;
        endcase
        return legs;
    endfunction

endpackage

// File: rtl/tour_leg_decode.sv
// Combinational decode of one move byte into two leg commands plus a legality flag.
module tour_leg_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move_oh,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd,
    output logic        legal
);

    leg_cmds_t legs;

    // Decode legs and flag anything other than exactly one set bit.
    always_comb begin
        legs     = move_legs(move_oh);
        vert_cmd = legs.vert;
        horz_cmd = legs.horz;
        legal    = (move_oh != 8'd0) && ((move_oh & (move_oh - 8'd1)) == 8'd0);
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Tour command sequencer: walks the move store, issues vertical/horizontal leg commands,
// muxes them with UART commands and produces the response byte.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int unsigned NUM_MOVES = 24,
    parameter int unsigned TO_CYCLES = 0,
    parameter logic [3:0]  ABORT_OPC = 4'hF,
    parameter logic [7:0]  DONE_RESP = 8'hA5,
    parameter logic [7:0]  BUSY_RESP = 8'h5A,
    localparam int unsigned IDX_W    = $clog2(NUM_MOVES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic             clr_abort,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_err
);

    localparam int unsigned      TO_W     = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = (TO_CYCLES == 0) ? '0 : TO_W'(TO_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    tour_state_t      state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
    logic [7:0]       move_q, move_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             tour_err_q, tour_err_d;
    logic             tour_busy_q;
    // Remembers which leg was in flight when an abort sent us to DRAIN.
    logic             drain_horz_q, drain_horz_d;

    logic [7:0]  dec_move;
    logic [15:0] vert_cmd, horz_cmd;
    logic        move_legal;
    logic        last_idx, in_wait, timeout, abort_req, abort_take;

    // In FETCH the live store output is checked; afterwards the captured move drives the legs.
    assign dec_move = (state_q == StFetch) ? move : move_q;

    tour_leg_decode u_leg_decode (
        .move_oh  (dec_move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd),
        .legal    (move_legal)
    );

    // Event decode and next-state logic; priority is timeout > abort > handshakes.
    always_comb begin
        state_d      = state_q;
        mv_indx_d    = mv_indx_q;
        move_d       = move_q;
        tour_err_d   = tour_err_q;
        drain_horz_d = drain_horz_q;
        abort_take   = 1'b0;

        last_idx  = (mv_indx_q == LAST_IDX);
        in_wait   = (state_q == StVwait) || (state_q == StHwait) || (state_q == StDrain);
        timeout   = (TO_CYCLES != 0) && in_wait && (to_cnt_q == TO_LAST);
        abort_req = cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OPC) && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start_tour) begin
                    mv_indx_d  = '0;
                    tour_err_d = 1'b0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                move_d = move;
                if (!move_legal) begin
                    tour_err_d = 1'b1;
                    state_d    = StIdle;
                end else if (abort_req) begin
                    abort_take = 1'b1;
                    state_d    = StIdle;
                end else begin
                    state_d = StVert;
                end
            end
            StVert: begin
                if (abort_req) begin
                    abort_take = 1'b1;
                    state_d    = StIdle;
                end else if (clr_cmd_rdy) begin
                    state_d = StVwait;
                end
            end
            StVwait: begin
                if (timeout) begin
                    tour_err_d = 1'b1;
                    state_d    = StIdle;
                end else if (abort_req) begin
                    abort_take   = 1'b1;
                    drain_horz_d = 1'b0;
                    state_d      = StDrain;
                end else if (send_resp) begin
                    state_d = StHorz;
                end
            end
            StHorz: begin
                if (abort_req) begin
                    abort_take = 1'b1;
                    state_d    = StIdle;
                end else if (clr_cmd_rdy) begin
                    state_d = StHwait;
                end
            end
            StHwait: begin
                if (timeout) begin
                    tour_err_d = 1'b1;
                    state_d    = StIdle;
                end else if (abort_req) begin
                    abort_take   = 1'b1;
                    drain_horz_d = 1'b1;
                    state_d      = StDrain;
                end else if (send_resp) begin
                    if (last_idx) begin
                        state_d = StIdle;
                    end else begin
                        mv_indx_d = mv_indx_q + IDX_W'(1);
                        state_d   = StFetch;
                    end
                end
            end
            StDrain: begin
                if (timeout) begin
                    tour_err_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    // A repeated abort here is simply consumed.
                    abort_take = abort_req;
                    if (send_resp) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Counter restarts on every entry into a wait state.
        if (in_wait && (state_d == state_q)) to_cnt_d = to_cnt_q + TO_W'(1);
        else                                 to_cnt_d = '0;
    end

    // Command/ready source mux and response byte.
    always_comb begin
        cmd     = 16'd0;
        cmd_rdy = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
            end
            StFetch: cmd = 16'd0;
            StVert: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
            end
            StVwait: cmd = vert_cmd;
            StHorz: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            StHwait: cmd = horz_cmd;
            StDrain: cmd = drain_horz_q ? horz_cmd : vert_cmd;
            default: cmd = 16'd0;
        endcase

        if ((state_q == StIdle) ||
            (((state_q == StHorz) || (state_q == StHwait)) && last_idx)) resp = DONE_RESP;
        else                                                             resp = BUSY_RESP;
    end

    // Reset wins over an abort arriving in the same cycle.
    assign clr_abort = abort_take && !rst;
    assign mv_indx   = mv_indx_q;
    assign tour_busy = tour_busy_q;
    assign tour_err  = tour_err_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mv_indx_q    <= '0;
            move_q       <= 8'd0;
            to_cnt_q     <= '0;
            tour_err_q   <= 1'b0;
            tour_busy_q  <= 1'b0;
            drain_horz_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mv_indx_q    <= mv_indx_d;
            move_q       <= move_d;
            to_cnt_q     <= to_cnt_d;
            tour_err_q   <= tour_err_d;
            tour_busy_q  <= (state_d != StIdle);
            drain_horz_q <= drain_horz_d;
        end
    end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Parametrised tour command sequencer between the tour solver's move store and `cmd_proc`. It expands each stored one-hot knight move into a vertical-leg and a horizontal-leg move command. It multiplexes these with UART commands and generates the response byte. It adds configurable tour length, a registered move-fetch stage, an illegal-move check, a per-leg response timeout, and a UART abort during a tour.

## Interface
- `NUM_MOVES`, 24: moves per tour; `IDX_W = $clog2(NUM_MOVES)` (derived, localparam).
- `TO_CYCLES`, 0: cycles allowed in a wait state before timeout; 0 disables timeout.
- `ABORT_OPC`, 4'hF: `cmd_UART[15:12]` value that aborts a running tour.
- `DONE_RESP` / `BUSY_RESP`, 8'hA5 / 8'h5A: response bytes.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_tour`  in  1  solver done; starts a tour, honoured in IDLE only.
- `move`  in  8  one-hot move read at `mv_indx`, valid one cycle after `mv_indx` changes.
- `mv_indx`  out  IDX_W  move address.
- `cmd_UART`, `cmd_rdy_UART`  in  16, 1  command and ready from UART_wrapper.
- `cmd`, `cmd_rdy`  out  16, 1  muxed command and ready to cmd_proc.
- `clr_cmd_rdy`, `send_resp`  in  1, 1  from cmd_proc.
- `clr_abort`  out  1  one-cycle pulse clearing the consumed abort command in UART_wrapper.
- `resp`  out  8  response byte.
- `tour_busy`  out  1  high from leaving IDLE until return to IDLE.
- `tour_err`  out  1  sticky flag: illegal move or timeout; cleared on the next accepted `start_tour`.

## Operation
- States: IDLE, FETCH, VERT, VWAIT, HORZ, HWAIT, DRAIN.
- **IDLE**
  - Source select = UART: `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`.
  - `start_tour` → clear `mv_indx` and `tour_err`, go to FETCH.
- **Tour states** (all except IDLE)
  - Source select = tour.
  - `cmd_rdy` is high only in VERT and HORZ.
  - `cmd` holds the current leg's command through its wait state; it is 0 in FETCH.
- **FETCH**
  - Lasts one cycle; captures `move` into `move_q`.
  - `move` not exactly one bit set → set `tour_err`, go to IDLE; `mv_indx` is left at the failing index.
  - Otherwise go to VERT.
- **Leg handshake**
  - VERT: `clr_cmd_rdy` → VWAIT; VWAIT: `send_resp` → HORZ.
  - HORZ: `clr_cmd_rdy` → HWAIT.
  - HWAIT: `send_resp` with `mv_indx != NUM_MOVES-1` → increment `mv_indx`, go to FETCH.
  - HWAIT: `send_resp` with `mv_indx == NUM_MOVES-1` → go to IDLE.
- **Command format:** `{opc[3:0], hdg[7:0], sq[3:0]}`. Vertical leg opc=4, horizontal leg opc=5 (fanfare). Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- **Leg mapping:** (vertical squares/heading ; horizontal squares/heading)
  - bit0: N2 ; E1
  - bit1: N2 ; W1
  - bit2: N1 ; W2
  - bit3: S1 ; W2
  - bit4: S2 ; W1
  - bit5: S2 ; E1
  - bit6: S1 ; E2
  - bit7: N1 ; E2
- **`resp`:** `DONE_RESP` in IDLE or when `mv_indx == NUM_MOVES-1` in HORZ/HWAIT; `BUSY_RESP` otherwise.
- **Abort:** `cmd_rdy_UART` with `cmd_UART[15:12] == ABORT_OPC` while `tour_busy`:
  - pulse `clr_abort` the same cycle;
  - in FETCH, VERT or HORZ: go to IDLE next cycle, dropping `cmd_rdy`;
  - in VWAIT or HWAIT: go to DRAIN;
  - DRAIN holds `cmd`, and `send_resp` → IDLE.
  - `tour_err` is not set by an abort.
  - Non-abort UART commands during a tour are not forwarded; UART_wrapper holds them until IDLE.
- **Timeout:** counter cleared on entry to VWAIT, HWAIT or DRAIN. Reaching `TO_CYCLES` with no `send_resp` → set `tour_err`, go to IDLE.
- **Reset:** state=IDLE; `mv_indx`=0; `move_q`=0; timeout counter=0; `tour_err`=0; `clr_abort`=0. Hence `cmd`/`cmd_rdy` follow UART, `resp` = `DONE_RESP`, `tour_busy`=0. `rst` mid-tour aborts immediately with no drain.

## Timing
- `start_tour` at cycle n → FETCH at n+1, `mv_indx`=0 → VERT at n+2 with `cmd_rdy`=1.
- `clr_cmd_rdy` in cycle k → `cmd_rdy` low at k+1.
- HWAIT `send_resp` at k → FETCH at k+1 with the new `mv_indx` → next VERT at k+2.
- Simultaneous events, in priority order: `rst` > timeout > abort > `send_resp`/`clr_cmd_rdy`.
- `start_tour` outside IDLE is ignored.
- `mv_indx` never exceeds NUM_MOVES-1; there is no wrap.
- `tour_busy` is registered and equals (state != IDLE).

## Structure
- Package `tour_pkg`:
  - state enum `tour_state_t`;
  - heading constants `HDG_N/W/S/E`;
  - opcodes `OPC_MOVE=4`, `OPC_FANFARE=5`;
  - function `move_legs(move)` returning both leg commands.
- Sub-module `tour_leg_decode`: combinational, `move_q` → vertical/horizontal commands and a `legal` flag.
- FSM, counters and muxes live in the top module.

## Test plan
- NUM_MOVES=24, `move`=8'h01 for all entries, immediate handshakes:
  - `cmd` sequence 16'h4002, 16'h5BF1 repeated 24 times;
  - `mv_indx` 0→23;
  - `resp` = 8'h5A until index 23, then 8'hA5;
  - IDLE after the last `send_resp`.
- All eight one-hot moves at indices 0–7 → exact commands per the leg mapping (e.g. bit3 → 16'h47F1, 16'h53F2).
- `move`=8'h03 at index 5 → `tour_err`=1, IDLE, `mv_indx`=5, `cmd` follows `cmd_UART`.
- Abort 16'hF000 during VERT → `clr_abort` pulse, IDLE next cycle. Abort during VWAIT → DRAIN, `cmd` held, IDLE after `send_resp`, `tour_err`=0.
- TO_CYCLES=100, `send_resp` withheld in HWAIT → `tour_err`=1 exactly 100 cycles after HWAIT entry, then IDLE.
- NUM_MOVES=8; `rst` asserted at index 3 → all outputs at reset values next cycle; new `start_tour` restarts at `mv_indx`=0.
